// File: rtl/ptl_split_pair_checker_pkg.sv
// Shared state encoding, saturation limits and modular age helper for the split-pair checker.
package ptl_chk_pkg;

  typedef logic [1:0] state_t;

  localparam state_t BAL    = 2'd0;
  localparam state_t B_LEAD = 2'd1;
  localparam state_t C_LEAD = 2'd2;

  localparam logic [31:0] PAIR_CNT_MAX = 32'hFFFF_FFFF;
  localparam logic [15:0] ERR_CNT_MAX  = 16'hFFFF;

  // Age of a timestamp relative to now, modulo 2**w, so counter wrap is transparent.
  function automatic logic [31:0] ts_age(input logic [31:0] now, input logic [31:0] ts,
                                         input int unsigned w);
    logic [31:0] diff;
    diff = now - ts;
    if (w < 32) begin
      diff = diff & ((32'd1 << w) - 32'd1);
    end
    return diff;
  endfunction

endpackage

// File: rtl/ptl_split_pair_checker_if.sv
// Branch pulse inputs and pairing/error outputs of the split-pair checker.
// Statistics signals exist only when PTL_SPLIT_CHK_STATS_EN is defined.
interface ptl_split_pair_checker_if
  import ptl_chk_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TS_W  = 8
);
  logic                   b_in;
  logic                   c_in;
  logic                   pair_valid;
  logic [TS_W-1:0]        pair_skew;
  logic                   pair_b_first;
  logic                   lost_err;
  logic                   ovf_err;
  logic [$clog2(DEPTH):0] pending;
`ifdef PTL_SPLIT_CHK_STATS_EN
  logic [31:0]            pair_cnt;
  logic [15:0]            lost_cnt;
  logic [15:0]            ovf_cnt;
  logic [TS_W-1:0]        max_skew;
`endif

  modport master (
    output b_in, c_in,
    input  pair_valid, pair_skew, pair_b_first, lost_err, ovf_err, pending
`ifdef PTL_SPLIT_CHK_STATS_EN
    , input pair_cnt, lost_cnt, ovf_cnt, max_skew
`endif
  );

  modport slave (
    input  b_in, c_in,
    output pair_valid, pair_skew, pair_b_first, lost_err, ovf_err, pending
`ifdef PTL_SPLIT_CHK_STATS_EN
    , output pair_cnt, lost_cnt, ovf_cnt, max_skew
`endif
  );

endinterface

// File: rtl/ptl_split_pair_checker_ts_fifo.sv
// Synchronous DEPTH x TS_W timestamp FIFO; push into a full FIFO is accepted only alongside a pop.
module ptl_ts_fifo
  import ptl_chk_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TS_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [TS_W-1:0]        din,
  output logic [TS_W-1:0]        head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [TS_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]   rptr_q, wptr_q;
  logic [AW:0]     count_q;
  logic            do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ptl_split_pair_checker.sv
// Pairs b/c pulses from a 2-way PTL splitter, reports skew and flags lost or excess pulses.
// Optional statistics outputs enabled by PTL_SPLIT_CHK_STATS_EN.
module ptl_split_pair_checker
  import ptl_chk_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TS_W     = 8,
  parameter int unsigned SKEW_MAX = 16
) (
  input logic                     clk,
  input logic                     rst,
  ptl_split_pair_checker_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [TS_W-1:0] now_q;
  state_t          state_q, state_d;

  logic            push, pop, full, empty;
  logic [TS_W-1:0] head;
  logic [CW-1:0]   count;

  logic            pv_q, pv_d;
  logic [TS_W-1:0] skew_q, skew_d;
  logic            bf_q, bf_d;
  logic            lost_q, ovf_q;
  logic            lost_set, ovf_set;
  logic [31:0]     age;
  logic            lead, trail;

  ptl_ts_fifo #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (now_q),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign age = ts_age(32'(now_q), 32'(head), TS_W);

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    pop      = 1'b0;
    pv_d     = 1'b0;
    skew_d   = '0;
    bf_d     = 1'b0;
    lost_set = 1'b0;
    ovf_set  = 1'b0;
    lead     = (state_q == B_LEAD) ? bus.b_in : bus.c_in;
    trail    = (state_q == B_LEAD) ? bus.c_in : bus.b_in;
    case (state_q)
      B_LEAD, C_LEAD: begin
        if (trail) begin
          pop    = 1'b1;
          pv_d   = 1'b1;
          skew_d = age[TS_W-1:0];
          bf_d   = (state_q == B_LEAD);
        end else if (!empty && age > SKEW_MAX) begin
          pop      = 1'b1;
          lost_set = 1'b1;
        end
        if (lead) begin
          if (full && !pop) ovf_set = 1'b1;
          else              push    = 1'b1;
        end
        // Leading states always hold at least one entry.
        if (pop && !push && count == CW'(1)) state_d = BAL;
      end
      default: begin
        if (bus.b_in && bus.c_in) begin
          pv_d = 1'b1;
        end else if (bus.b_in) begin
          push    = 1'b1;
          state_d = B_LEAD;
        end else if (bus.c_in) begin
          push    = 1'b1;
          state_d = C_LEAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      now_q   <= '0;
      state_q <= BAL;
      pv_q    <= 1'b0;
      skew_q  <= '0;
      bf_q    <= 1'b0;
      lost_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      now_q   <= now_q + 1'b1;
      state_q <= state_d;
      pv_q    <= pv_d;
      skew_q  <= skew_d;
      bf_q    <= bf_d;
      lost_q  <= lost_q | lost_set;
      ovf_q   <= ovf_q | ovf_set;
    end
  end

  assign bus.pair_valid   = pv_q;
  assign bus.pair_skew    = skew_q;
  assign bus.pair_b_first = bf_q;
  assign bus.lost_err     = lost_q;
  assign bus.ovf_err      = ovf_q;
  assign bus.pending      = count;

`ifdef PTL_SPLIT_CHK_STATS_EN
  logic [31:0]     pair_cnt_q;
  logic [15:0]     lost_cnt_q, ovf_cnt_q;
  logic [TS_W-1:0] max_skew_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_cnt_q <= '0;
      lost_cnt_q <= '0;
      ovf_cnt_q  <= '0;
      max_skew_q <= '0;
    end else begin
      if (pv_d && pair_cnt_q != PAIR_CNT_MAX)  pair_cnt_q <= pair_cnt_q + 1'b1;
      if (lost_set && lost_cnt_q != ERR_CNT_MAX) lost_cnt_q <= lost_cnt_q + 1'b1;
      if (ovf_set && ovf_cnt_q != ERR_CNT_MAX)  ovf_cnt_q  <= ovf_cnt_q + 1'b1;
      if (pv_d && skew_d > max_skew_q)          max_skew_q <= skew_d;
    end
  end

  assign bus.pair_cnt = pair_cnt_q;
  assign bus.lost_cnt = lost_cnt_q;
  assign bus.ovf_cnt  = ovf_cnt_q;
  assign bus.max_skew = max_skew_q;
`endif

endmodule

// File: tb/tb_ptl_split_pair_checker.sv
// Scoreboard bench for ptl_split_pair_checker: expected pairs queued at stimulus, checked on pair_valid.
module tb_ptl_split_pair_checker;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TS_W  = 8;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] tb_now;

  int n_checks = 0;
  int n_fail   = 0;

  // Entry layout: {b_first, skew}
  logic [TS_W:0] exp_q [$];

  ptl_split_pair_checker_if #(.DEPTH(DEPTH), .TS_W(TS_W)) bus ();

  ptl_split_pair_checker #(
    .DEPTH    (DEPTH),
    .TS_W     (TS_W),
    .SKEW_MAX (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tb_now <= rst ? 8'd0 : tb_now + 8'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.pair_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("pair_unexpected", 32'(bus.pair_valid), 32'd0);
      end else begin
        logic [TS_W:0] e;
        e = exp_q.pop_front();
        check("pair_skew", 32'(bus.pair_skew), 32'(e[TS_W-1:0]));
        check("pair_b_first", 32'(bus.pair_b_first), 32'(e[TS_W]));
      end
    end
  end

  task automatic pulse(input logic b, input logic c);
    bus.b_in = b;
    bus.c_in = c;
    @(posedge clk);
    #1;
    bus.b_in = 1'b0;
    bus.c_in = 1'b0;
  endtask

  task automatic wait_now(input logic [7:0] target);
    int n;
    n = 0;
    while (tb_now != target && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (tb_now != target) check("wait_now", 32'(tb_now), 32'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic expect_pair(input logic [TS_W-1:0] skew, input logic bf);
    exp_q.push_back({bf, skew});
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(bus.pair_valid), 32'd0);
    check({tag, "_pending"}, 32'(bus.pending), 32'd0);
    check({tag, "_lost"}, 32'(bus.lost_err), 32'd0);
    check({tag, "_ovf"}, 32'(bus.ovf_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    bus.b_in = 1'b0;
    bus.c_in = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    check_idle("reset");
    check("reset_skew", 32'(bus.pair_skew), 32'd0);
    check("reset_bfirst", 32'(bus.pair_b_first), 32'd0);

    // Simultaneous b/c from balance
    wait_now(8'd10);
    expect_pair(8'd0, 1'b0);
    pulse(1'b1, 1'b1);
    check("sim_pending", 32'(bus.pending), 32'd0);

    // b leads by 7
    do_reset();
    wait_now(8'd5);
    pulse(1'b1, 1'b0);
    check("blead_pending", 32'(bus.pending), 32'd1);
    wait_now(8'd12);
    expect_pair(8'd7, 1'b1);
    pulse(1'b0, 1'b1);
    check("blead_pending0", 32'(bus.pending), 32'd0);

    // Three c leads of 5
    do_reset();
    wait_now(8'd3);
    repeat (3) pulse(1'b0, 1'b1);
    check("clead_pending3", 32'(bus.pending), 32'd3);
    wait_now(8'd8);
    repeat (3) begin
      expect_pair(8'd5, 1'b0);
      pulse(1'b1, 1'b0);
    end
    check("clead_pending0", 32'(bus.pending), 32'd0);

    // C_LEAD with same-cycle pop and push
    do_reset();
    wait_now(8'd20);
    pulse(1'b0, 1'b1);
    wait_now(8'd22);
    expect_pair(8'd2, 1'b0);
    pulse(1'b1, 1'b1);
    check("popush_pending", 32'(bus.pending), 32'd1);
    wait_now(8'd25);
    expect_pair(8'd3, 1'b0);
    pulse(1'b1, 1'b0);
    check("popush_pending0", 32'(bus.pending), 32'd0);

    // Lost pulse: b at 0, never matched
    do_reset();
    pulse(1'b1, 1'b0);
    wait_now(8'd17);
    check("lost_age16_err", 32'(bus.lost_err), 32'd0);
    check("lost_age16_pending", 32'(bus.pending), 32'd1);
    wait_now(8'd18);
    check("lost_err", 32'(bus.lost_err), 32'd1);
    check("lost_pending", 32'(bus.pending), 32'd0);
    wait_now(8'd22);
    check("lost_sticky", 32'(bus.lost_err), 32'd1);
    check("lost_no_ovf", 32'(bus.ovf_err), 32'd0);

    // Overflow on fifth b, then reset with 3 pending
    do_reset();
    repeat (4) pulse(1'b1, 1'b0);
    check("ovf_pending4", 32'(bus.pending), 32'd4);
    check("ovf_before", 32'(bus.ovf_err), 32'd0);
    pulse(1'b1, 1'b0);
    check("ovf_err", 32'(bus.ovf_err), 32'd1);
    check("ovf_pending_hold", 32'(bus.pending), 32'd4);
    expect_pair(8'd5, 1'b1);
    pulse(1'b0, 1'b1);
    check("ovf_pending3", 32'(bus.pending), 32'd3);
    do_reset();
    check_idle("midrst");
    check("midrst_sb", 32'(exp_q.size()), 32'd0);
    wait_now(8'd2);
    pulse(1'b0, 1'b1);
    check("midrst_clead", 32'(bus.pending), 32'd1);

    // Pair straddling timestamp wrap
    do_reset();
    wait_now(8'd250);
    pulse(1'b1, 1'b0);
    wait_now(8'd3);
    expect_pair(8'd9, 1'b1);
    pulse(1'b0, 1'b1);
    check("wrap_pending", 32'(bus.pending), 32'd0);
    check("wrap_lost", 32'(bus.lost_err), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
